// File: rtl/cordic_ci_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cordic_ci_ctrl_if
// Purpose  : Custom-instruction side bundle of the CORDIC cosine controller.
//            The processor (master) issues a start with an angle and later
//            receives a one-cycle done with the cosine result.
// Signals  : clk_en  - custom-instruction clock enable (master -> slave)
//            start   - start pulse                     (master -> slave)
//            dataa   - IEEE-754 single angle           (master -> slave)
//            done    - one-cycle result-valid pulse    (slave -> master)
//            result  - IEEE-754 single cosine          (slave -> master)
//            busy    - controller not idle             (slave -> master)
//            err     - result came from a timeout      (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface cordic_ci_ctrl_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;
  logic        busy;
  logic        err;

  modport master (output clk_en, start, dataa, input done, result, busy, err);
  modport slave  (input clk_en, start, dataa, output done, result, busy, err);
endinterface
`default_nettype wire

// File: rtl/cordic_ci_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cordic_ci_ctrl
// Purpose  : Sequencer wrapping an iterative CORDIC cosine core as a
//            multi-cycle custom instruction. Latches the angle, loads the
//            core, lets it rotate until it reports done (or a timeout
//            expires) and returns the captured result with a done pulse.
//            Zero/denormal angles bypass the core and return 1.0.
// Ports    : clock        - single clock, rising edge
//            aclr         - asynchronous active-low reset
//            ci           - custom-instruction bundle (slave side)
//            core_aclr    - synchronous active-high clear for the core
//            core_clk_en  - clock enable for the core
//            core_start   - load strobe for the core
//            core_dataa   - latched angle presented to the core
//            core_done    - core has reached its final rotation index
//            core_result  - core float result
// Revision : 1.0 - initial release
// ============================================================================
module cordic_ci_ctrl #(
  parameter int ITERATIONS = 16,
  parameter int TIMEOUT    = 24
) (
  input  logic            clock,
  input  logic            aclr,
  cordic_ci_ctrl_if.slave ci,
  output logic            core_aclr,
  output logic            core_clk_en,
  output logic            core_start,
  output logic [31:0]     core_dataa,
  input  logic            core_done,
  input  logic [31:0]     core_result
);

  // The normal path needs ITERATIONS+1 RUN cycles; the timeout must leave
  // room for that and fit the 5-bit counter.
  if ((TIMEOUT < 2) || (TIMEOUT > 32) || (ITERATIONS + 1 > TIMEOUT)) begin : g_param_check
    $error("cordic_ci_ctrl: TIMEOUT must lie in [ITERATIONS+1, 32]");
  end

  localparam logic [31:0] c_one     = 32'h3F80_0000;
  localparam logic [4:0]  c_to_last = 5'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cycle_cnt;
  logic        done_q;
  logic        err_q;
  logic [31:0] result_q;
  logic        bypass;
  logic        timeout_hit;

  // Exponent field zero means +/-0 or a denormal: cosine is 1.0 to single
  // precision, so the core is not needed.
  assign bypass      = (ci.dataa[30:23] == 8'd0);
  assign timeout_hit = (cycle_cnt == c_to_last);

  assign ci.done   = done_q;
  assign ci.err    = err_q;
  assign ci.result = result_q;
  assign ci.busy   = (state != IDLE);

  // Core clear: high during reset and through the first edge after release.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      core_aclr <= 1'b1;
    end else begin
      core_aclr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    core_start  = 1'b0;
    core_clk_en = 1'b0;
    case (state)
      IDLE: begin
        if (ci.start) begin
          state_nxt = bypass ? FIN : LOAD;
        end
      end
      LOAD: begin
        // Gated by clk_en so a stalled LOAD still loads the core only once.
        core_start  = ci.clk_en;
        core_clk_en = ci.clk_en;
        state_nxt   = RUN;
      end
      RUN: begin
        // Freeze the core as soon as it reports its final index.
        core_clk_en = ci.clk_en & ~core_done;
        if (core_done || timeout_hit) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      core_dataa <= '0;
      cycle_cnt  <= '0;
    end else if (ci.clk_en) begin
      state  <= state_nxt;
      done_q <= (state_nxt == FIN);
      case (state)
        IDLE: begin
          if (ci.start) begin
            core_dataa <= ci.dataa;
            if (bypass) begin
              result_q <= c_one;
              err_q    <= 1'b0;
            end
          end
        end
        LOAD: begin
          cycle_cnt <= '0;
        end
        RUN: begin
          if (core_done) begin
            result_q <= core_result;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= core_result;
            err_q    <= 1'b1;
          end
          if (cycle_cnt != 5'h1F) begin
            cycle_cnt <= cycle_cnt + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_ci_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cordic_ci_ctrl
// Purpose  : Self-checking bench for cordic_ci_ctrl. A model core counts
//            rotation indices; a transaction-level reference model predicts
//            every output from the operation's age in enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_ci_ctrl;
  localparam int ITER = 16;
  localparam int TO   = 24;

  logic        clock = 1'b0;
  logic        aclr  = 1'b0;
  logic        core_aclr;
  logic        core_clk_en;
  logic        core_start;
  logic [31:0] core_dataa;
  logic        core_done;
  logic [31:0] core_result;

  cordic_ci_ctrl_if ci();

  cordic_ci_ctrl #(.ITERATIONS(ITER), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .aclr        (aclr),
    .ci          (ci),
    .core_aclr   (core_aclr),
    .core_clk_en (core_clk_en),
    .core_start  (core_start),
    .core_dataa  (core_dataa),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model CORDIC core ----------------
  bit          stuck       = 1'b0;
  logic [31:0] core_res_val = 32'h3F0A_5140;
  int          idx         = 0;
  always @(posedge clock) begin
    if (core_aclr)        idx <= 0;
    else if (core_clk_en) idx <= core_start ? 0 : ((idx < 31) ? idx + 1 : idx);
  end
  assign core_done   = !stuck && (idx == ITER);
  assign core_result = core_res_val;

  // ---------------- reference model ----------------
  // An accepted operation completes after D enabled edges: 1 (bypass),
  // 1 LOAD + ITER+1 RUN + 1 (normal) or 1 LOAD + TO RUN + 1 (timeout).
  bit          m_active = 0, m_bypass = 0, m_stuck = 0, m_err = 0, m_pend_err = 0, m_coreaclr = 1;
  int          m_age = 0, m_D = 0;
  logic [31:0] m_result = '0, m_dataa = '0, m_pend = '0;

  always @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      m_active <= 0; m_age <= 0; m_result <= '0; m_err <= 0; m_dataa <= '0; m_coreaclr <= 1;
    end else begin
      m_coreaclr <= 0;
      if (ci.clk_en) begin
        if (!m_active) begin
          if (ci.start) begin
            m_active <= 1; m_age <= 1; m_dataa <= ci.dataa;
            if (ci.dataa[30:23] == 8'd0) begin
              m_bypass <= 1; m_D <= 1; m_result <= 32'h3F80_0000; m_err <= 0;
            end else begin
              m_bypass <= 0; m_stuck <= stuck; m_D <= stuck ? TO + 2 : ITER + 3;
              m_pend <= core_res_val; m_pend_err <= stuck;
            end
          end
        end else if (m_age >= m_D) begin
          m_active <= 0; m_age <= 0;
        end else begin
          m_age <= m_age + 1;
          if (m_age + 1 == m_D) begin
            m_result <= m_pend; m_err <= m_pend_err;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_on = 0;
  always @(negedge clock) begin
    if (chk_on) begin
      bit e_done, e_cs, e_cen;
      e_done = m_active && (m_age == m_D);
      e_cs   = m_active && !m_bypass && (m_age == 1) && ci.clk_en;
      e_cen  = m_active && !m_bypass && ci.clk_en && (m_age <= (m_stuck ? m_D - 1 : m_D - 2));
      check("done",        32'(ci.done),     32'(e_done));
      check("busy",        32'(ci.busy),     32'(m_active));
      check("err",         32'(ci.err),      32'(m_err));
      check("result",      ci.result,        m_result);
      check("core_dataa",  core_dataa,       m_dataa);
      check("core_aclr",   32'(core_aclr),   32'(m_coreaclr));
      check("core_start",  32'(core_start),  32'(e_cs));
      check("core_clk_en", 32'(core_clk_en), 32'(e_cen));
    end
  end

  // ---------------- directed operation ----------------
  task automatic run_op(input logic [31:0] a, input bit stk, input logic [31:0] cres,
                        input int exp_lat, input int exp_nd, input logic [31:0] exp_res,
                        input bit exp_err, input logic [31:0] exp_dataa,
                        input int exp_cs, input int exp_cen,
                        input int stall_at, input int inj_at, input int rst_at);
    int s0, lat, nd, ncs, ncen;
    core_res_val = cres; stuck = stk;
    @(posedge clock); #1;
    ci.start = 1'b1; ci.dataa = a; s0 = cyc;
    lat = -1; nd = 0; ncs = 0; ncen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      ci.start = (k == inj_at);
      if (k == inj_at) ci.dataa = 32'h4000_0000;
      ci.clk_en = !((stall_at > 0) && (k >= stall_at) && (k < stall_at + 5));
      if (rst_at > 0 && k == rst_at)     aclr = 1'b0;
      if (rst_at > 0 && k == rst_at + 2) aclr = 1'b1;
      @(negedge clock);
      if (ci.done) begin
        nd++;
        if (lat < 0) lat = cyc - s0;
      end
      if (core_start)  ncs++;
      if (core_clk_en) ncen++;
      if (rst_at > 0 && k == rst_at + 2) check("core_aclr_release_cycle", 32'(core_aclr), 32'd1);
      if (rst_at > 0 && k == rst_at + 3) check("core_aclr_after_release", 32'(core_aclr), 32'd0);
    end
    check("latency",        32'(lat),    32'(exp_lat));
    check("done_count",     32'(nd),     32'(exp_nd));
    check("final_result",   ci.result,   exp_res);
    check("final_err",      32'(ci.err), 32'(exp_err));
    check("final_dataa",    core_dataa,  exp_dataa);
    check("core_start_cnt", 32'(ncs),    32'(exp_cs));
    check("core_clk_en_cnt",32'(ncen),   32'(exp_cen));
  endtask

  initial begin
    ci.clk_en = 1'b1; ci.start = 1'b0; ci.dataa = '0;
    aclr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_on = 1;
    check("rst_done",       32'(ci.done),   32'd0);
    check("rst_busy",       32'(ci.busy),   32'd0);
    check("rst_result",     ci.result,      32'd0);
    check("rst_core_dataa", core_dataa,     32'd0);
    check("rst_core_aclr",  32'(core_aclr), 32'd1);
    aclr = 1'b1;
    @(negedge clock);
    check("core_aclr_first_cycle", 32'(core_aclr), 32'd1);
    @(posedge clock); #1;
    check("core_aclr_low", 32'(core_aclr), 32'd0);

    // normal 1.0
    run_op(32'h3F80_0000, 0, 32'h3F0A_5140, 19, 1, 32'h3F0A_5140, 0, 32'h3F80_0000, 1, 17, 0, 0, 0);
    // zero bypass
    run_op(32'h0000_0000, 0, 32'h1234_5678, 1, 1, 32'h3F80_0000, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    // core never finishes -> timeout
    run_op(32'h3F80_0000, 1, 32'h3E00_0000, 26, 1, 32'h3E00_0000, 1, 32'h3F80_0000, 1, 25, 0, 0, 0);
    // reset at cycle +10: no done, no residual err
    run_op(32'h3F80_0000, 0, 32'h3F00_0000, -1, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 9, 0, 0, 10);
    // second start during RUN ignored
    run_op(32'h3F80_0000, 0, 32'h3F4A_0000, 19, 1, 32'h3F4A_0000, 0, 32'h3F80_0000, 1, 17, 0, 5, 0);
    // clk_en low 5 cycles mid-RUN
    run_op(32'h3F80_0000, 0, 32'h3F11_1111, 24, 1, 32'h3F11_1111, 0, 32'h3F80_0000, 1, 17, 6, 0, 0);
    // start coinciding with FIN ignored
    run_op(32'h3F80_0000, 0, 32'h3F22_2222, 19, 1, 32'h3F22_2222, 0, 32'h3F80_0000, 1, 17, 0, 19, 0);
    // negative denormal bypass
    run_op(32'h8040_0000, 0, 32'h3F33_3333, 1, 1, 32'h3F80_0000, 0, 32'h8040_0000, 0, 0, 0, 0, 0);
    // negative angle keeps its sign at the core
    run_op(32'hBF80_0000, 0, 32'h3F0A_5140, 19, 1, 32'h3F0A_5140, 0, 32'hBF80_0000, 1, 17, 0, 0, 0);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_ci_ctrl.md
CORDIC_CI_CTRL -- requirements
Module: cordic_ci_ctrl

Interface
REQ-001 SHALL have parameter ITERATIONS, default 16, meaning the core rotation count at which the core reports done.
REQ-002 SHALL have parameter TIMEOUT, default 24, meaning the maximum RUN cycles before a forced abort.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port aclr, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port clk_en, input, 1, the custom-instruction clock enable.
REQ-006 SHALL have port start, input, 1, the custom-instruction start pulse.
REQ-007 SHALL have port dataa, input, 32, the IEEE-754 single-precision angle.
REQ-008 SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-009 SHALL have port result, output, 32, the IEEE-754 cosine result, held until the next done.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port err, output, 1, high with done when the result came from a timeout abort.
REQ-012 SHALL have port core_aclr, output, 1, the active-high synchronous clear for the CORDIC core.
REQ-013 SHALL have port core_clk_en, output, 1, the clock enable for the CORDIC core.
REQ-014 SHALL have port core_start, output, 1, the start/load strobe for the CORDIC core.
REQ-015 SHALL have port core_dataa, output, 32, the latched angle presented to the core.
REQ-016 SHALL have port core_done, input, 1, the core's rotate_index==ITERATIONS flag.
REQ-017 SHALL have port core_result, input, 32, the core's float result.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, FIN.
REQ-019 SHALL advance the FSM, counters and registers only when clk_en=1; when clk_en=0, all state holds and core_clk_en=0.
REQ-020 IDLE: on start=1, SHALL latch dataa into core_dataa; if dataa[30:23]==0 (zero or denormal), SHALL load result=32'h3F800000, clear err and go to FIN (bypass); otherwise SHALL go to LOAD.
REQ-021 LOAD: SHALL drive core_start=1 and core_clk_en=1 for exactly one cycle, clear the cycle counter and go to RUN.
REQ-022 RUN: core_clk_en SHALL be combinationally !core_done, so the core freezes at index ITERATIONS.
REQ-023 RUN with core_done=1: SHALL capture core_result into result, clear err and go to FIN.
REQ-024 RUN with counter==TIMEOUT-1 and core_done=0: SHALL capture core_result, set err=1 and go to FIN.
REQ-025 The RUN cycle counter SHALL be 5 bits wide and saturate, never wrap.
REQ-026 FIN: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-027 done SHALL be a registered output: done=1 iff state==FIN.
REQ-028 Latency (clk_en held 1, normal path): done SHALL be high 19 cycles after the start cycle (1 LOAD + 17 RUN + 1 FIN edge).
REQ-029 Latency (bypass path): done SHALL be high on the cycle after the start cycle.
REQ-030 start asserted while busy=1 SHALL be ignored, with no effect on state, core_dataa or result.
REQ-031 start and a FIN cycle coinciding SHALL be ignored; a new start is accepted only in IDLE.
REQ-032 dataa sign SHALL pass through unchanged to core_dataa; cosine evenness is the core's responsibility.

Reset
REQ-033 aclr=0 SHALL asynchronously force state=IDLE, done=0, busy=0, err=0, result=0, core_dataa=0, counter=0, core_start=0, core_clk_en=0.
REQ-034 core_aclr SHALL be 1 while aclr=0 and for exactly one clock after aclr deasserts, then 0.
REQ-035 A reset mid-operation SHALL abandon the operation, emit no done and leave no residual err.

Verification
REQ-036 Reset release, then start with dataa=32'h3F800000 (1.0) and a model core (done at index 16) -> core_start for one cycle, done at cycle +19, result=core_result, err=0.
REQ-037 start with dataa=32'h00000000 -> done next cycle, result=32'h3F800000, no core_start pulse.
REQ-038 Core model whose core_done never rises, TIMEOUT=24 -> done with err=1 at cycle +26, core_clk_en high for 24 RUN cycles.
REQ-039 Second start during RUN with dataa=32'h40000000 -> ignored, core_dataa remains 32'h3F800000, single done.
REQ-040 clk_en=0 for 5 cycles mid-RUN -> core_clk_en=0 throughout, done delayed by exactly 5 cycles, result unchanged.
REQ-041 aclr pulsed low at cycle +10 of an operation -> no done, all outputs 0, core_aclr high through the cycle after release.
